// File: rtl/tt_um_hardy_alu_acc_if.sv
// Operand/result handshake bundle for the accumulating ALU.
interface tt_um_hardy_alu_acc_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, op_count
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, op_count
  );
endinterface

// File: rtl/tt_um_hardy_alu_acc.sv
// Single-stage ALU with accumulator, valid/ready handshake on both sides,
// optional saturation and an accepted-operation counter.
module tt_um_hardy_alu_acc #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst_n,
  input logic ena,
  tt_um_hardy_alu_acc_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] acc_n;
  logic             carry_n;
  logic             accept;
  logic             consume;

  assign op = op_t'(bus.op);

  // The output register can take a new result when empty or being drained.
  assign bus.in_ready  = ena & (~valid_q | bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = valid_q & bus.out_ready;

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.op_count  = count_q;

  // ADD and ACC share one WIDTH+1 adder; only the operand selection differs.
  assign add_x = (op == OP_ACC) ? acc_q : bus.a;
  assign add_y = (op == OP_ACC) ? bus.a : bus.b;
  assign sum   = {1'b0, add_x} + {1'b0, add_y};

  // Next result, carry/borrow and accumulator value for the presented op.
  always_comb begin
    res_n   = '0;
    carry_n = 1'b0;
    acc_n   = acc_q;
    case (op)
      OP_ADD: begin
        carry_n = sum[WIDTH];
        res_n   = (SATURATE != 0 && carry_n) ? '1 : sum[WIDTH-1:0];
      end
      OP_SUB: begin
        carry_n = (bus.a < bus.b);
        res_n   = (SATURATE != 0 && carry_n) ? '0 : bus.a - bus.b;
      end
      OP_ACC: begin
        carry_n = sum[WIDTH];
        res_n   = (SATURATE != 0 && carry_n) ? '1 : sum[WIDTH-1:0];
        acc_n   = res_n;
      end
      OP_CLR: begin
        acc_n = '0;
      end
      default: ;
    endcase
  end

  // Result/accumulator/counter registers; reset wins over everything, ena freezes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else if (ena) begin
      if (accept) begin
        result_q <= res_n;
        carry_q  <= carry_n;
        valid_q  <= 1'b1;
        acc_q    <= acc_n;
        count_q  <= count_q + 1'b1;
      end else if (consume) begin
        valid_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_hardy_alu_acc.sv
// Scoreboard bench: wrapping and saturating instances driven with identical stimulus.
module tb_tt_um_hardy_alu_acc;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  always #5 clk = ~clk;

  tt_um_hardy_alu_acc_if #(.WIDTH(8), .CNT_W(8)) bus0 ();
  tt_um_hardy_alu_acc_if #(.WIDTH(8), .CNT_W(8)) bus1 ();

  tt_um_hardy_alu_acc #(.WIDTH(8), .SATURATE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus0)
  );
  tt_um_hardy_alu_acc #(.WIDTH(8), .SATURATE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] m_acc0 = '0;
  logic [7:0] m_acc1 = '0;
  logic [7:0] m_cnt  = '0;
  bit         mon_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU: returns {carry, result}, updates accumulator copy.
  function automatic logic [8:0] alu(input logic [1:0] o, input logic [7:0] xa,
                                     input logic [7:0] xb, input bit sat,
                                     input logic [7:0] acc_in, output logic [7:0] acc_out);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    acc_out = acc_in;
    r = '0;
    c = 1'b0;
    case (o)
      2'd0: begin
        s = {1'b0, xa} + {1'b0, xb};
        c = s[8];
        r = (sat && c) ? 8'hFF : s[7:0];
      end
      2'd1: begin
        c = (xa < xb);
        r = (sat && c) ? 8'h00 : 8'(xa - xb);
      end
      2'd2: begin
        s = {1'b0, acc_in} + {1'b0, xa};
        c = s[8];
        r = (sat && c) ? 8'hFF : s[7:0];
        acc_out = r;
      end
      default: begin
        acc_out = '0;
      end
    endcase
    return {c, r};
  endfunction

  // Model update on each edge: pop consumed results, push newly accepted ones.
  always @(posedge clk) begin
    logic       acc_ok;
    logic [7:0] na;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_acc0 = '0;
      m_acc1 = '0;
      m_cnt  = '0;
    end else if (ena) begin
      acc_ok = bus0.in_valid && (q0.size() == 0 || bus0.out_ready);
      if (q0.size() != 0 && bus0.out_ready) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc_ok) begin
        q0.push_back(alu(bus0.op, bus0.a, bus0.b, 1'b0, m_acc0, na));
        m_acc0 = na;
        q1.push_back(alu(bus1.op, bus1.a, bus1.b, 1'b1, m_acc1, na));
        m_acc1 = na;
        m_cnt  = m_cnt + 8'd1;
      end
    end
  end

  // Mid-cycle comparison of both instances against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("ov0", bus0.out_valid, q0.size() != 0);
      check_val("ov1", bus1.out_valid, q1.size() != 0);
      check_val("ir0", bus0.in_ready, ena && (q0.size() == 0 || bus0.out_ready));
      check_val("ir1", bus1.in_ready, ena && (q1.size() == 0 || bus1.out_ready));
      check_val("cnt0", bus0.op_count, m_cnt);
      check_val("cnt1", bus1.op_count, m_cnt);
      if (q0.size() != 0) begin
        check_val("res0", {bus0.carry, bus0.result}, q0[0]);
        check_val("res1", {bus1.carry, bus1.result}, q1[0]);
      end
    end
  end

  // One clock of stimulus applied identically to both instances.
  task automatic cyc(input logic v, input logic [1:0] o, input logic [7:0] xa,
                     input logic [7:0] xb, input logic ordy);
    bus0.in_valid = v;  bus1.in_valid = v;
    bus0.op = o;        bus1.op = o;
    bus0.a = xa;        bus1.a = xa;
    bus0.b = xb;        bus1.b = xb;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic chk_both(input string tag, input logic [7:0] r0, input logic c0,
                          input logic [7:0] r1, input logic c1);
    check_val({tag, "_r0"}, bus0.result, r0);
    check_val({tag, "_c0"}, bus0.carry, c0);
    check_val({tag, "_r1"}, bus1.result, r1);
    check_val({tag, "_c1"}, bus1.carry, c1);
  endtask

  initial begin
    logic [7:0] acc_seq [5];
    logic [7:0] acc_exp [5];
    acc_seq = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd7};
    acc_exp = '{8'd10, 8'd30, 8'd60, 8'd0, 8'd7};

    ena   = 1'b1;
    rst_n = 1'b0;
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    mon_en = 1'b1;
    check_val("rst_ov", bus0.out_valid, 1'b0);
    chk_both("rst", 8'd0, 1'b0, 8'd0, 1'b0);
    check_val("rst_cnt", bus0.op_count, 8'd0);
    check_val("rst_ir", bus0.in_ready, 1'b1);
    rst_n = 1'b1;

    // Wrap vs saturate on ADD and SUB.
    cyc(1'b1, 2'd0, 8'd200, 8'd100, 1'b1);
    check_val("add_ov", bus0.out_valid, 1'b1);
    chk_both("add", 8'd44, 1'b1, 8'd255, 1'b1);
    check_val("add_cnt", bus0.op_count, 8'd1);
    cyc(1'b1, 2'd1, 8'd5, 8'd7, 1'b1);
    chk_both("sub", 8'd254, 1'b1, 8'd0, 1'b1);
    cyc(1'b1, 2'd1, 8'd7, 8'd7, 1'b1);
    chk_both("sub_eq", 8'd0, 1'b0, 8'd0, 1'b0);

    // Accumulate / clear, with an ADD that must not disturb the accumulator.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i == 3) ? 2'd3 : 2'd2, acc_seq[i], 8'd0, 1'b1);
      chk_both($sformatf("acc%0d", i), acc_exp[i], 1'b0, acc_exp[i], 1'b0);
      if (i == 1) begin
        cyc(1'b1, 2'd0, 8'd1, 8'd1, 1'b1);
        chk_both("add11", 8'd2, 1'b0, 8'd2, 1'b0);
      end
    end
    cyc(1'b1, 2'd2, 8'd250, 8'd0, 1'b1);
    chk_both("acc_ovf", 8'd1, 1'b1, 8'd255, 1'b1);

    // Backpressure.
    do_reset();
    cyc(1'b1, 2'd0, 8'd3, 8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'd0, 8'd9, 8'd9, 1'b0);
      chk_both("bp_hold", 8'd7, 1'b0, 8'd7, 1'b0);
      check_val("bp_ir", bus0.in_ready, 1'b0);
      check_val("bp_cnt", bus0.op_count, 8'd1);
    end
    cyc(1'b1, 2'd0, 8'd9, 8'd9, 1'b1);
    chk_both("bp_next", 8'd18, 1'b0, 8'd18, 1'b0);
    check_val("bp_cnt2", bus0.op_count, 8'd2);
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    check_val("drain_ov", bus0.out_valid, 1'b0);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 255; i++) cyc(1'b1, 2'd0, 8'(i), 8'd1, 1'b1);
    check_val("cnt_255", bus0.op_count, 8'd255);
    cyc(1'b1, 2'd0, 8'd1, 8'd1, 1'b1);
    check_val("cnt_wrap", bus0.op_count, 8'd0);

    // Back-to-back random stream with a 3-cycle enable gap.
    for (int i = 0; i < 300; i++) begin
      ena = !(i >= 150 && i < 153);
      cyc(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1);
    end
    ena = 1'b1;

    // Random valid/ready mix.
    for (int i = 0; i < 300; i++) begin
      ena = ($urandom_range(0, 9) != 0);
      cyc(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    ena = 1'b1;

    // Reset right after an ACC accept.
    do_reset();
    cyc(1'b1, 2'd2, 8'd10, 8'd0, 1'b1);
    cyc(1'b1, 2'd2, 8'd20, 8'd0, 1'b1);
    cyc(1'b1, 2'd2, 8'd30, 8'd0, 1'b1);
    chk_both("pre_rst", 8'd60, 1'b0, 8'd60, 1'b0);
    rst_n = 1'b0;
    cyc(1'b1, 2'd2, 8'd5, 8'd0, 1'b1);
    rst_n = 1'b1;
    check_val("mid_rst_ov", bus0.out_valid, 1'b0);
    chk_both("mid_rst", 8'd0, 1'b0, 8'd0, 1'b0);
    check_val("mid_rst_cnt", bus0.op_count, 8'd0);
    cyc(1'b1, 2'd2, 8'd5, 8'd0, 1'b1);
    chk_both("acc_after_rst", 8'd5, 1'b0, 8'd5, 1'b0);

    // Reset still applies with ena low; in_ready follows ena afterwards.
    cyc(1'b1, 2'd0, 8'd1, 8'd1, 1'b0);
    ena   = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);
    rst_n = 1'b1;
    check_val("rst_noena_ov", bus1.out_valid, 1'b0);
    check_val("rst_noena_cnt", bus1.op_count, 8'd0);
    check_val("rst_noena_ir", bus0.in_ready, 1'b0);
    ena = 1'b1;
    #1;
    check_val("rst_ena_ir", bus0.in_ready, 1'b1);
    cyc(1'b0, 2'd0, 8'd0, 8'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
